// File: rtl/arith_unit_param.sv
// Sequential add/sub, radix-2 Booth multiply and non-restoring unsigned divide on WIDTH-bit words.
// Latency bgn->stop: add/sub 4, mul WIDTH+4, div WIDTH+5, div-by-zero 4; no backpressure, bgn ignored when busy.
module arith_unit_param #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             bgn,
   input  logic [1:0]       opcode,
   input  logic [WIDTH-1:0] inbus,
   output logic [WIDTH-1:0] outbus,
   output logic             stop,
   output logic             ovf,
   output logic             dz
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD_X  = 3'd1;
   localparam logic [2:0] S_LOAD_Y  = 3'd2;
   localparam logic [2:0] S_EXEC    = 3'd3;
   localparam logic [2:0] S_DIV_FIX = 3'd4;
   localparam logic [2:0] S_OUT_HI  = 3'd5;
   localparam logic [2:0] S_OUT_LO  = 3'd6;

   logic [2:0]       state;
   logic [1:0]       op;
   // A carries one guard bit so Booth (-2^(W-1) operands) and non-restoring partial remainders never overflow.
   logic [WIDTH:0]   a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic             q_m1;
   logic [CW-1:0]    cnt;
   logic             ovf_q;
   logic             dz_q;

   logic [WIDTH:0]   m_sx;
   logic [WIDTH:0]   m_zx;
   logic [WIDTH-1:0] y_eff;
   logic [WIDTH-1:0] sum_as;
   logic             add_ovf;
   logic [WIDTH:0]   a_bth;
   logic [WIDTH:0]   a_sh;
   logic [WIDTH:0]   a_div;
   logic             last;

   always_comb begin
      m_sx    = {m[WIDTH-1], m};
      m_zx    = {1'b0, m};
      y_eff   = q ^ {WIDTH{op[0]}};
      sum_as  = m + y_eff + {{(WIDTH-1){1'b0}}, op[0]};
      add_ovf = (m[WIDTH-1] == y_eff[WIDTH-1]) && (sum_as[WIDTH-1] != m[WIDTH-1]);
      case ({q[0], q_m1})
         2'b10:   a_bth = a - m_sx;
         2'b01:   a_bth = a + m_sx;
         default: a_bth = a;
      endcase
      a_sh  = {a[WIDTH-1:0], q[WIDTH-1]};
      a_div = a[WIDTH] ? (a_sh + m_zx) : (a_sh - m_zx);
      last  = (cnt == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state <= S_IDLE;
         op    <= 2'b00;
         a     <= '0;
         q     <= '0;
         m     <= '0;
         q_m1  <= 1'b0;
         cnt   <= '0;
         ovf_q <= 1'b0;
         dz_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bgn) begin
                  op    <= opcode;
                  state <= S_LOAD_X;
               end
            end
            S_LOAD_X: begin
               m     <= inbus;
               state <= S_LOAD_Y;
            end
            S_LOAD_Y: begin
               a     <= '0;
               q_m1  <= 1'b0;
               cnt   <= '0;
               ovf_q <= 1'b0;
               dz_q  <= 1'b0;
               if (op == 2'b11) begin
                  if (inbus == '0) begin
                     a     <= {1'b0, m};
                     q     <= '1;
                     dz_q  <= 1'b1;
                     state <= S_OUT_HI;
                  end else begin
                     // divide keeps the dividend in Q and the divisor in M
                     q     <= m;
                     m     <= inbus;
                     state <= S_EXEC;
                  end
               end else begin
                  q     <= inbus;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!op[1]) begin
                  a     <= {1'b0, sum_as};
                  ovf_q <= add_ovf;
                  state <= S_OUT_LO;
               end else if (!op[0]) begin
                  a     <= {a_bth[WIDTH], a_bth[WIDTH:1]};
                  q     <= {a_bth[0], q[WIDTH-1:1]};
                  q_m1  <= q[0];
                  cnt   <= last ? '0 : cnt + 1'b1;
                  if (last) state <= S_OUT_HI;
               end else begin
                  a     <= a_div;
                  q     <= {q[WIDTH-2:0], ~a_div[WIDTH]};
                  cnt   <= last ? '0 : cnt + 1'b1;
                  if (last) state <= S_DIV_FIX;
               end
            end
            S_DIV_FIX: begin
               if (a[WIDTH]) a <= a + m_zx;
               state <= S_OUT_HI;
            end
            S_OUT_HI: state <= S_OUT_LO;
            S_OUT_LO: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      outbus = '0;
      stop   = 1'b0;
      ovf    = 1'b0;
      dz     = 1'b0;
      if (state == S_OUT_HI) begin
         outbus = a[WIDTH-1:0];
      end else if (state == S_OUT_LO) begin
         outbus = op[1] ? q : a[WIDTH-1:0];
         stop   = 1'b1;
         ovf    = ovf_q;
         dz     = dz_q;
      end
   end

endmodule

// File: tb/tb_arith_unit_param.sv
// Drives WIDTH=8 and WIDTH=64 instances in lockstep; checks against fixed vectors and an arithmetic reference model.
module tb_arith_unit_param;

   localparam int NCYC = 76;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        bgn;
   logic [1:0]  opcode;
   logic [63:0] inbus;
   logic [7:0]  out8;
   logic        stop8, ovf8, dz8;
   logic [63:0] out64;
   logic        stop64, ovf64, dz64;

   always #5 clk = ~clk;

   arith_unit_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_b(rst_b), .bgn(bgn), .opcode(opcode), .inbus(inbus[7:0]),
      .outbus(out8), .stop(stop8), .ovf(ovf8), .dz(dz8));

   arith_unit_param #(.WIDTH(64)) dut64 (
      .clk(clk), .rst_b(rst_b), .bgn(bgn), .opcode(opcode), .inbus(inbus),
      .outbus(out64), .stop(stop64), .ovf(ovf64), .dz(dz64));

   typedef struct packed {
      logic [63:0] hi;
      logic [63:0] lo;
      logic        ov;
      logic        dz;
      int          lat;
   } res_t;

   typedef struct packed {
      logic [1:0]  op;
      logic [63:0] x;
      logic [63:0] y;
      logic [7:0]  w;
      logic [63:0] hi;
      logic [63:0] lo;
      logic        ov;
      logic        dz;
      int          lat;
   } vec_t;

   int errors = 0;
   int checks = 0;

   logic [63:0] ob8 [NCYC];
   logic [63:0] ob64[NCYC];
   logic        st8 [NCYC], st64[NCYC];
   logic        ov8 [NCYC], ov64[NCYC];
   logic        dzr8[NCYC], dzr64[NCYC];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: true signed/unsigned arithmetic on wide integers, reduced to w bits.
   function automatic res_t model(input int w, input logic [1:0] op, input logic [63:0] x, input logic [63:0] y);
      res_t r;
      logic [129:0] one, msk, ux, uy;
      logic signed [129:0] sx, sy, s, lim;
      one = 130'd1;
      msk = (one << w) - one;
      ux  = {66'd0, x} & msk;
      uy  = {66'd0, y} & msk;
      sx  = ux;
      if (ux[w-1]) sx = ux - (one << w);
      sy  = uy;
      if (uy[w-1]) sy = uy - (one << w);
      lim = one << (w - 1);
      r   = '0;
      case (op)
         2'b00, 2'b01: begin
            s     = op[0] ? (sx - sy) : (sx + sy);
            r.lo  = 64'(s & msk);
            r.ov  = (s >= lim) || (s < -lim);
            r.lat = 4;
         end
         2'b10: begin
            s     = sx * sy;
            r.hi  = 64'((s >> w) & msk);
            r.lo  = 64'(s & msk);
            r.lat = w + 4;
         end
         default: begin
            if (uy == 130'd0) begin
               r.hi  = 64'(ux);
               r.lo  = 64'(msk);
               r.dz  = 1'b1;
               r.lat = 4;
            end else begin
               r.hi  = 64'(ux % uy);
               r.lo  = 64'(ux / uy);
               r.lat = w + 5;
            end
         end
      endcase
      return r;
   endfunction

   task automatic sample(input int n);
      ob8[n]  = {56'd0, out8};
      st8[n]  = stop8;
      ov8[n]  = ovf8;
      dzr8[n] = dz8;
      ob64[n]  = out64;
      st64[n]  = stop64;
      ov64[n]  = ovf64;
      dzr64[n] = dz64;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y);
      @(negedge clk);
      bgn    = 1'b1;
      opcode = op;
      inbus  = 64'($urandom);
      for (int n = 1; n < NCYC; n++) begin
         @(negedge clk);
         sample(n);
         bgn    = 1'b0;
         opcode = 2'($urandom);
         inbus  = (n == 1) ? x : (n == 2) ? y : {$urandom, $urandom};
      end
   endtask

   task automatic check_dut(input string tag, input int w, input logic op1, input res_t e);
      int first, nstop, spur;
      logic [63:0] o [NCYC];
      logic        s [NCYC];
      logic        f [NCYC];
      logic        vo, vd;
      first = -1;
      nstop = 0;
      spur  = 0;
      vo    = 1'b0;
      vd    = 1'b0;
      for (int n = 1; n < NCYC; n++) begin
         o[n] = (w == 8) ? ob8[n] : ob64[n];
         s[n] = (w == 8) ? st8[n] : st64[n];
         f[n] = (w == 8) ? (ov8[n] | dzr8[n]) : (ov64[n] | dzr64[n]);
         if (s[n]) begin
            nstop++;
            if (first < 0) begin
               first = n;
               vo = (w == 8) ? ov8[n] : ov64[n];
               vd = (w == 8) ? dzr8[n] : dzr64[n];
            end
         end
      end
      chk({tag, ".stops"}, 64'(nstop), 64'd1);
      chk({tag, ".latency"}, 64'(first), 64'(e.lat));
      if (first > 1) begin
         chk({tag, ".lo"}, o[first], e.lo);
         chk({tag, ".ovf"}, {63'd0, vo}, {63'd0, e.ov});
         chk({tag, ".dz"}, {63'd0, vd}, {63'd0, e.dz});
         if (op1) chk({tag, ".hi"}, o[first-1], e.hi);
         for (int n = 1; n < NCYC; n++)
            if (n != first && (f[n] || (o[n] != 64'd0 && !(op1 && n == first - 1)))) spur++;
         chk({tag, ".idle_zero"}, 64'(spur), 64'd0);
      end
   endtask

   vec_t vecs[12];

   initial begin
      res_t e8, e64;
      logic [15:0] m8, m64;
      int stops;

      vecs[0]  = '{2'b00, 64'h7F, 64'h01, 8'd8, 64'h0, 64'h80, 1'b1, 1'b0, 4};
      vecs[1]  = '{2'b01, 64'h05, 64'h07, 8'd8, 64'h0, 64'hFE, 1'b0, 1'b0, 4};
      vecs[2]  = '{2'b10, 64'hFD, 64'h07, 8'd8, 64'hFF, 64'hEB, 1'b0, 1'b0, 12};
      vecs[3]  = '{2'b11, 64'd200, 64'd7, 8'd8, 64'h04, 64'h1C, 1'b0, 1'b0, 13};
      vecs[4]  = '{2'b11, 64'd200, 64'd0, 8'd8, 64'd200, 64'hFF, 1'b0, 1'b1, 4};
      vecs[5]  = '{2'b10, 64'h80, 64'h80, 8'd8, 64'h40, 64'h00, 1'b0, 1'b0, 12};
      vecs[6]  = '{2'b01, 64'h80, 64'h01, 8'd8, 64'h0, 64'h7F, 1'b1, 1'b0, 4};
      vecs[7]  = '{2'b11, 64'hFF, 64'h01, 8'd8, 64'h00, 64'hFF, 1'b0, 1'b0, 13};
      vecs[8]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 8'd64, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 68};
      vecs[9]  = '{2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 8'd64, 64'h4000_0000_0000_0000, 64'h0, 1'b0, 1'b0, 68};
      vecs[10] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 8'd64, 64'h0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 4};
      vecs[11] = '{2'b11, 64'd1000000007, 64'd10, 8'd64, 64'd7, 64'd100000000, 1'b0, 1'b0, 69};

      // reset state, with bgn asserted to confirm reset dominates
      rst_b  = 1'b0;
      bgn    = 1'b1;
      opcode = 2'b10;
      inbus  = 64'h0;
      repeat (3) @(negedge clk);
      chk("reset.out8", {56'd0, out8}, 64'd0);
      chk("reset.flags8", {61'd0, stop8, ovf8, dz8}, 64'd0);
      chk("reset.out64", out64, 64'd0);
      chk("reset.flags64", {61'd0, stop64, ovf64, dz64}, 64'd0);
      bgn   = 1'b0;
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle.stop", {62'd0, stop8, stop64}, 64'd0);

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].x, vecs[i].y);
         e8  = model(8, vecs[i].op, vecs[i].x, vecs[i].y);
         e64 = model(64, vecs[i].op, vecs[i].x, vecs[i].y);
         if (vecs[i].w == 8) e8 = '{vecs[i].hi, vecs[i].lo, vecs[i].ov, vecs[i].dz, vecs[i].lat};
         else e64 = '{vecs[i].hi, vecs[i].lo, vecs[i].ov, vecs[i].dz, vecs[i].lat};
         check_dut($sformatf("vec%0d/w8", i), 8, vecs[i].op[1], e8);
         check_dut($sformatf("vec%0d/w64", i), 64, vecs[i].op[1], e64);
      end

      // reset in the middle of a multiply EXEC, then a fresh add
      @(negedge clk);
      bgn    = 1'b1;
      opcode = 2'b10;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         bgn   = 1'b0;
         inbus = (n == 1) ? 64'd5 : (n == 2) ? 64'd3 : {$urandom, $urandom};
         if (n == 6) rst_b = 1'b0;
      end
      @(negedge clk);
      chk("abort.out", {56'd0, out8} | out64, 64'd0);
      chk("abort.stop", {62'd0, stop8, stop64}, 64'd0);
      rst_b = 1'b1;
      stops = 0;
      repeat (80) begin
         @(negedge clk);
         stops += int'(stop8) + int'(stop64);
      end
      chk("abort.no_stop", 64'(stops), 64'd0);
      run_op(2'b00, 64'd3, 64'd4);
      check_dut("after_abort/w8", 8, 1'b0, '{64'd0, 64'd7, 1'b0, 1'b0, 4});
      check_dut("after_abort/w64", 64, 1'b0, '{64'd0, 64'd7, 1'b0, 1'b0, 4});

      // bgn held through EXEC, OUT_LO and the following IDLE: restart only from IDLE
      @(negedge clk);
      bgn    = 1'b1;
      opcode = 2'b00;
      m8     = '0;
      m64    = '0;
      for (int n = 1; n < 16; n++) begin
         @(negedge clk);
         sample(n);
         m8[n]  = stop8;
         m64[n] = stop64;
         bgn    = (n >= 3 && n <= 5);
         opcode = (n == 5) ? 2'b01 : 2'($urandom);
         inbus  = (n == 1) ? 64'd10 : (n == 2) ? 64'd20 : (n == 6) ? 64'd50 : (n == 7) ? 64'd8 : {$urandom, $urandom};
      end
      chk("hold.stops8", {48'd0, m8}, 64'h0210);
      chk("hold.stops64", {48'd0, m64}, 64'h0210);
      chk("hold.first8", ob8[4], 64'd30);
      chk("hold.second8", ob8[9], 64'd42);
      chk("hold.second64", ob64[9], 64'd42);
      repeat (3) @(negedge clk);

      // randomized operands against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  op;
         logic [63:0] x, y;
         op = 2'($urandom);
         x  = {$urandom, $urandom};
         y  = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: y = 64'd0;
            1: x = 64'h8000_0000_0000_0080;
            2: y = 64'h7FFF_FFFF_FFFF_FF7F;
            3: y = {56'd0, 8'($urandom_range(1, 15))};
            default: ;
         endcase
         run_op(op, x, y);
         check_dut($sformatf("rand%0d/w8", i), 8, op[1], model(8, op, x, y));
         check_dut($sformatf("rand%0d/w64", i), 64, op[1], model(64, op, x, y));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
